// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width; a 1-bit floor keeps the counter legal for tiny widths.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/ready/done request bus between a datapath and the serial adder.
// The sub request line exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input ready, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output ready, done, sum, cout);
`else
  modport master (output start, a, b, cin, input ready, done, sum, cout);
  modport slave  (input start, a, b, cin, output ready, done, sum, cout);
`endif

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the serial datapath.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full adder cell stepped LSB-first over WIDTH cycles.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               reset,
  serial_adder_ctrl_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_b_load;
  logic             w_carry_load;

  full_adder u_fa (
    .A    (r_a_sh[0]),
    .B    (r_b_sh[0]),
    .Cin  (r_carry),
    .S    (w_s),
    .Cout (w_fa_cout)
  );

  assign w_last = (r_cnt == LAST_BIT);

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert b and force the initial carry to 1.
  assign w_b_load     = bus.sub ? ~bus.b : bus.b;
  assign w_carry_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign w_b_load     = bus.b;
  assign w_carry_load = bus.cin;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    bus.ready    = 1'b0;
    bus.done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.done     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath registers; operands are only loaded on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a_sh  <= bus.a;
      r_b_sh  <= w_b_load;
      r_carry <= w_carry_load;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_carry <= w_fa_cout;
      if (w_last) begin
        r_cout <= w_fa_cout;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=2 instances).
module tb_serial_adder_ctrl;

  logic clk;
  logic reset;
  int   assertions;
  int   failures;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(2)) bus2 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  serial_adder_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on the 8-bit DUT; lat counts edges from accept to done.
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic ci, output int lat);
    bus8.a = av;
    bus8.b = bv;
    bus8.cin = ci;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    lat = 1;
    tick();
    while (bus8.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    $display("issue8 a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d lat=%0d", av, bv, ci, bus8.sum, bus8.cout, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick(); tick();
    assertions++;
    if (bus8.ready !== 1'b1 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: ready=%b done=%b sum=%02h cout=%b required 1 0 00 0",
               bus8.ready, bus8.done, bus8.sum, bus8.cout);
    end
    reset = 1'b0;
    tick();
    assertions++;
    if (bus8.ready !== 1'b1 || bus8.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b done=%b required 1 0", bus8.ready, bus8.done);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int lat;
    issue8(8'h0F, 8'h01, 1'b0, lat);
    assertions++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL basic_latency: got %0d edges required 8", lat);
    end
    assertions++;
    if (bus8.sum !== 8'h10 || bus8.cout !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: sum=%02h cout=%b required 10 0", bus8.sum, bus8.cout);
    end
    tick();
    assertions++;
    if (bus8.done !== 1'b0 || bus8.ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_after_done: done=%b ready=%b required 0 1", bus8.done, bus8.ready);
    end
    assertions++;
    if (bus8.sum !== 8'h10) begin
      failures++;
      $display("FAIL basic_hold: sum=%02h required 10", bus8.sum);
    end
  endtask

  task automatic test_carry();
    int lat;
    issue8(8'hFF, 8'h01, 1'b0, lat);
    assertions++;
    if (lat !== 8 || bus8.sum !== 8'h00 || bus8.cout !== 1'b1) begin
      failures++;
      $display("FAIL carry_ff01: lat=%0d sum=%02h cout=%b required 8 00 1", lat, bus8.sum, bus8.cout);
    end
    tick();
    issue8(8'hAA, 8'h55, 1'b1, lat);
    assertions++;
    if (lat !== 8 || bus8.sum !== 8'h00 || bus8.cout !== 1'b1) begin
      failures++;
      $display("FAIL carry_aa55: lat=%0d sum=%02h cout=%b required 8 00 1", lat, bus8.sum, bus8.cout);
    end
    tick();
  endtask

  task automatic test_start_held();
    int dones;
    logic [7:0] sum_at_done;
    logic       cout_at_done;
    dones = 0;
    sum_at_done = 8'hXX;
    cout_at_done = 1'bx;
    bus8.a = 8'h03;
    bus8.b = 8'h04;
    bus8.cin = 1'b0;
    bus8.start = 1'b1;
    tick();
    bus8.a = 8'hF0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (bus8.done === 1'b1) begin
        dones++;
        sum_at_done = bus8.sum;
        cout_at_done = bus8.cout;
      end
    end
    $display("start_held dones=%0d sum=%02h cout=%0d ready=%0d", dones, sum_at_done, cout_at_done, bus8.ready);
    assertions++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL held_done_count: got %0d required 1", dones);
    end
    assertions++;
    if (sum_at_done !== 8'h07 || cout_at_done !== 1'b0) begin
      failures++;
      $display("FAIL held_result: sum=%02h cout=%b required 07 0", sum_at_done, cout_at_done);
    end
    assertions++;
    if (bus8.ready !== 1'b1) begin
      failures++;
      $display("FAIL held_ready_back: ready=%b required 1", bus8.ready);
    end
    bus8.start = 1'b0;
    tick();
    assertions++;
    if (bus8.ready !== 1'b1 || bus8.sum !== 8'h07) begin
      failures++;
      $display("FAIL held_no_restart: ready=%b sum=%02h required 1 07", bus8.ready, bus8.sum);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    int lat;
    bus8.a = 8'h12;
    bus8.b = 8'h34;
    bus8.cin = 1'b0;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("reset_mid ready=%0d done=%0d sum=%02h cout=%0d", bus8.ready, bus8.done, bus8.sum, bus8.cout);
    assertions++;
    if (bus8.ready !== 1'b1 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: ready=%b done=%b sum=%02h cout=%b required 1 0 00 0",
               bus8.ready, bus8.done, bus8.sum, bus8.cout);
    end
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus8.done === 1'b1) dones++;
    end
    assertions++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL midrun_no_done: got %0d done pulses required 0", dones);
    end
    issue8(8'h12, 8'h34, 1'b0, lat);
    assertions++;
    if (lat !== 8 || bus8.sum !== 8'h46 || bus8.cout !== 1'b0) begin
      failures++;
      $display("FAIL midrun_fresh: lat=%0d sum=%02h cout=%b required 8 46 0", lat, bus8.sum, bus8.cout);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    // Next request is issued in the first ready cycle after done.
    issue8(8'h80, 8'h80, 1'b1, lat);
    assertions++;
    if (bus8.sum !== 8'h01 || bus8.cout !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: sum=%02h cout=%b required 01 1", bus8.sum, bus8.cout);
    end
    tick();
    issue8(8'h3C, 8'h41, 1'b0, lat);
    assertions++;
    if (lat !== 8 || bus8.sum !== 8'h7D || bus8.cout !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: lat=%0d sum=%02h cout=%b required 8 7D 0", lat, bus8.sum, bus8.cout);
    end
    tick();
  endtask

  task automatic test_sweep_w2();
    int lat;
    int exp_total;
    int bad;
    bad = 0;
    for (int v = 0; v < 32; v++) begin
      bus2.a = 2'(v >> 3);
      bus2.b = 2'(v >> 1);
      bus2.cin = v[0];
      exp_total = (v >> 3) + ((v >> 1) & 3) + (v & 1);
      bus2.start = 1'b1;
      tick();
      bus2.start = 1'b0;
      lat = 1;
      tick();
      while (bus2.done !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      $display("sweep a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d lat=%0d", bus2.a, bus2.b, bus2.cin, bus2.sum, bus2.cout, lat);
      assertions++;
      if (lat !== 2 || bus2.sum !== 2'(exp_total) || bus2.cout !== exp_total[2]) begin
        failures++;
        bad++;
        $display("FAIL sweep_w2 case %0d: lat=%0d sum=%0d cout=%b required lat 2 sum %0d cout %0d",
                 v, lat, bus2.sum, bus2.cout, exp_total & 3, exp_total >> 2);
      end
      tick();
      assertions++;
      if (bus2.done !== 1'b0 || bus2.ready !== 1'b1) begin
        failures++;
        $display("FAIL sweep_w2_pulse case %0d: done=%b ready=%b required 0 1", v, bus2.done, bus2.ready);
      end
    end
    $display("test_sweep_w2 mismatching cases=%0d", bad);
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int lat;
    bus8.sub = 1'b1;
    issue8(8'h05, 8'h07, 1'b0, lat);
    assertions++;
    if (bus8.sum !== 8'hFE || bus8.cout !== 1'b0) begin
      failures++;
      $display("FAIL sub_5_7: sum=%02h cout=%b required FE 0", bus8.sum, bus8.cout);
    end
    tick();
    issue8(8'h07, 8'h05, 1'b0, lat);
    assertions++;
    if (bus8.sum !== 8'h02 || bus8.cout !== 1'b1) begin
      failures++;
      $display("FAIL sub_7_5: sum=%02h cout=%b required 02 1", bus8.sum, bus8.cout);
    end
    tick();
    bus8.sub = 1'b0;
    issue8(8'h05, 8'h07, 1'b1, lat);
    assertions++;
    if (bus8.sum !== 8'h0D || bus8.cout !== 1'b0) begin
      failures++;
      $display("FAIL sub_off_add: sum=%02h cout=%b required 0D 0", bus8.sum, bus8.cout);
    end
    tick();
  endtask
`endif

  initial begin
    assertions = 0;
    failures = 0;
    reset = 1'b1;
    bus8.start = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus8.cin = 1'b0;
    bus2.start = 1'b0;
    bus2.a = '0;
    bus2.b = '0;
    bus2.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus8.sub = 1'b0;
    bus2.sub = 1'b0;
`endif
    test_reset();
    test_basic();
    test_carry();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    test_sweep_w2();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
